// File: rtl/spi_payload_gen.sv
// spi_payload_gen: SPI byte-stream source: preamble, sync header, NUM_FRAMES payload frames, trailer.
// Latency: busy 1 cycle after start, first spi_clk rise 1+CLK_DIV cycles after start; outputs registered.
// Backpressure: none; start is ignored while busy, abort drops back to idle on the next cycle.
// Build option: define SPI_PAYLOAD_GEN_LFSR_EN to build the LFSR payload source (pattern_mode=1).
module spi_payload_gen #(
  parameter int                       CLK_DIV        = 20,
  parameter int                       PREAMBLE_BYTES = 9,
  parameter logic [7:0]               HEADER         = 8'hFF,
  parameter int                       FRAME_BYTES    = 6,
  parameter int                       NUM_FRAMES     = 15,
  parameter int                       TRAILER_BYTES  = 2,
  parameter logic [FRAME_BYTES*8-1:0] PATTERN        = 48'hBBA0D2BBA0D2
) (
  input  logic        CLK_40,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  pattern_mode,
  input  logic [15:0] byte_gap,
  output logic        spi_clk,
  output logic        miso,
  output logic        busy,
  output logic        done,
  output logic [15:0] byte_count
);

  localparam int         PW       = FRAME_BYTES * 8;
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_BYTES - 1);
  localparam logic [15:0] FRM_LAST = 16'(FRAME_BYTES - 1);
  localparam logic [15:0] NF_LAST  = 16'(NUM_FRAMES - 1);
  localparam logic [15:0] TRL_LAST = 16'(TRAILER_BYTES - 1);
  localparam bit          HAS_PRE  = (PREAMBLE_BYTES > 0);
  localparam bit          HAS_TRL  = (TRAILER_BYTES > 0);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOW, S_HIGH, S_GAP, S_DONE} state_t;
  typedef enum logic [1:0] {SEC_PRE, SEC_HDR, SEC_PAY, SEC_TRL} sec_t;

  state_t      state;
  sec_t        sec;          // section of the next byte to fetch
  logic [15:0] sec_idx;      // byte index within preamble/trailer, or within the current frame
  logic [15:0] frame_idx;    // frame index inside the payload section
  logic [7:0]  pay_idx;      // running payload byte index, mod 256
  logic [7:0]  shreg;        // byte being shifted, MSB on miso
  logic [2:0]  bit_cnt;      // bits already completed in the current byte
  logic [15:0] cnt;          // half-period / gap cycle counter
  logic [15:0] gap_q;        // byte_gap captured at start
  logic [1:0]  mode_q;       // pattern_mode captured at start
  logic        last_q;       // byte in shreg is the final byte of the payload
`ifdef SPI_PAYLOAD_GEN_LFSR_EN
  logic [7:0]  lfsr;
`endif

  logic [PW-1:0] pat_tmp;
  logic [7:0]    pat_byte;
  logic [7:0]    pay_byte;
  logic [7:0]    ld_byte;
  sec_t          nx_sec;
  logic [15:0]   nx_idx;
  logic [15:0]   nx_frame;
  logic          ld_last;
  logic          div_end;
  logic          byte_end;
  logic          load_now;

  // Payload byte source for the current frame position and captured mode.
  always_comb begin
    pat_tmp  = PATTERN << {sec_idx, 3'b000};
    pat_byte = pat_tmp[PW-1 -: 8];
    pay_byte = pat_byte;
    case (mode_q)
`ifdef SPI_PAYLOAD_GEN_LFSR_EN
      2'd1:    pay_byte = lfsr;
`else
      2'd1:    pay_byte = pat_byte;
`endif
      2'd2:    pay_byte = pay_idx;
      2'd3:    pay_byte = ~pat_byte;
      default: pay_byte = pat_byte;
    endcase
  end

  // Byte to fetch next and where the section walker goes after it.
  always_comb begin
    ld_byte  = 8'h00;
    nx_sec   = sec;
    nx_idx   = sec_idx + 16'd1;
    nx_frame = frame_idx;
    ld_last  = 1'b0;
    case (sec)
      SEC_PRE: begin
        ld_byte = 8'h00;
        if (sec_idx == PRE_LAST) begin
          nx_sec = SEC_HDR;
          nx_idx = 16'd0;
        end
      end
      SEC_HDR: begin
        ld_byte  = HEADER;
        nx_sec   = SEC_PAY;
        nx_idx   = 16'd0;
        nx_frame = 16'd0;
      end
      SEC_PAY: begin
        ld_byte = pay_byte;
        if (sec_idx == FRM_LAST) begin
          nx_idx   = 16'd0;
          nx_frame = frame_idx + 16'd1;
          if (frame_idx == NF_LAST) begin
            nx_sec   = SEC_TRL;
            nx_frame = 16'd0;
            ld_last  = !HAS_TRL;
          end
        end
      end
      SEC_TRL: begin
        ld_byte = 8'h00;
        if (sec_idx == TRL_LAST) begin
          nx_idx  = 16'd0;
          ld_last = 1'b1;
        end
      end
      default: ld_byte = 8'h00;
    endcase
  end

  // With no gap the next byte is fetched on the last falling edge, so back-to-back bytes are 16*CLK_DIV apart.
  always_comb begin
    div_end  = (cnt == DIV_LAST);
    byte_end = (state == S_HIGH) && div_end && (bit_cnt == 3'd7);
    load_now = !abort && ((state == S_LOAD) || (byte_end && (gap_q == 16'd0) && !last_q));
  end

  // Main sequencer: bit timing, section walk, registered outputs.
  always_ff @(posedge CLK_40) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      sec        <= SEC_PRE;
      sec_idx    <= 16'd0;
      frame_idx  <= 16'd0;
      pay_idx    <= 8'd0;
      shreg      <= 8'd0;
      bit_cnt    <= 3'd0;
      cnt        <= 16'd0;
      gap_q      <= 16'd0;
      mode_q     <= 2'd0;
      last_q     <= 1'b0;
      spi_clk    <= 1'b0;
      miso       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_count <= 16'd0;
`ifdef SPI_PAYLOAD_GEN_LFSR_EN
      lfsr       <= 8'h01;
`endif
    end else begin
      done <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        // abort wins over everything, including a completion in the same cycle
        state   <= S_IDLE;
        spi_clk <= 1'b0;
        miso    <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state      <= S_LOAD;
              busy       <= 1'b1;
              mode_q     <= pattern_mode;
              gap_q      <= byte_gap;
              byte_count <= 16'd0;
              pay_idx    <= 8'd0;
              sec        <= HAS_PRE ? SEC_PRE : SEC_HDR;
              sec_idx    <= 16'd0;
              frame_idx  <= 16'd0;
`ifdef SPI_PAYLOAD_GEN_LFSR_EN
              lfsr       <= 8'h01;
`endif
            end
          end
          S_LOAD: begin
            state   <= S_LOW;
            cnt     <= 16'd0;
            bit_cnt <= 3'd0;
          end
          S_LOW: begin
            if (div_end) begin
              spi_clk <= 1'b1;
              cnt     <= 16'd0;
              state   <= S_HIGH;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_HIGH: begin
            if (div_end) begin
              spi_clk <= 1'b0;
              cnt     <= 16'd0;
              if (bit_cnt != 3'd7) begin
                shreg   <= {shreg[6:0], 1'b0};
                miso    <= shreg[6];
                bit_cnt <= bit_cnt + 3'd1;
                state   <= S_LOW;
              end else begin
                if (byte_count != 16'hFFFF)
                  byte_count <= byte_count + 16'd1;
                bit_cnt <= 3'd0;
                if (gap_q != 16'd0) begin
                  miso  <= 1'b0;
                  state <= S_GAP;
                end else if (last_q) begin
                  miso  <= 1'b0;
                  state <= S_DONE;
                end else begin
                  state <= S_LOW;
                end
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_GAP: begin
            if (cnt == gap_q - 16'd1) begin
              cnt   <= 16'd0;
              state <= last_q ? S_DONE : S_LOAD;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase

        if (load_now) begin
          shreg     <= ld_byte;
          miso      <= ld_byte[7];
          sec       <= nx_sec;
          sec_idx   <= nx_idx;
          frame_idx <= nx_frame;
          last_q    <= ld_last;
          if (sec == SEC_PAY) begin
            pay_idx <= pay_idx + 8'd1;
`ifdef SPI_PAYLOAD_GEN_LFSR_EN
            lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_payload_gen.sv
// tb_spi_payload_gen: scoreboard bench for spi_payload_gen (default build plus a minimal-size instance).
// Latency: checks start-to-rise, byte spacing and start-to-done cycle counts against the timing rules.
// Backpressure: exercises start-while-busy, abort mid-frame and reset mid-header.
module tb_spi_payload_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, abort;
  logic [1:0]  pattern_mode;
  logic [15:0] byte_gap;
  logic        spi_clk, miso, busy, done;
  logic [15:0] byte_count;

  logic        start_s, abort_s;
  logic [1:0]  pattern_mode_s;
  logic [15:0] byte_gap_s;
  logic        spi_clk_s, miso_s, busy_s, done_s;
  logic [15:0] byte_count_s;

  spi_payload_gen dut (
    .CLK_40(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .pattern_mode(pattern_mode), .byte_gap(byte_gap),
    .spi_clk(spi_clk), .miso(miso), .busy(busy), .done(done), .byte_count(byte_count)
  );

  spi_payload_gen #(
    .CLK_DIV(1), .PREAMBLE_BYTES(0), .HEADER(8'hFF), .FRAME_BYTES(1),
    .NUM_FRAMES(1), .TRAILER_BYTES(0), .PATTERN(8'h5A)
  ) dut_s (
    .CLK_40(clk), .reset_n(reset_n), .start(start_s), .abort(abort_s),
    .pattern_mode(pattern_mode_s), .byte_gap(byte_gap_s),
    .spi_clk(spi_clk_s), .miso(miso_s), .busy(busy_s), .done(done_s), .byte_count(byte_count_s)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // expected bytes for the default instance
  logic [7:0] exp_q[$];
  logic [7:0] exp_q_s[$];

  // SPI receiver on the default instance: samples miso where spi_clk has just risen
  logic [7:0] rx_sh = 8'h00;
  int         rx_bits = 0;
  int         rx_n = 0;
  int         last_rise = 0;
  logic       sclk_d = 1'b0;
  bit         gap_chk = 1'b0;
  always @(negedge clk) begin
    if (!busy) begin
      rx_bits = 0;
      rx_n    = 0;
    end else if (spi_clk && !sclk_d) begin
      if (gap_chk && rx_bits == 0 && rx_n > 0) check_val("byte_spacing", cyc - last_rise, 91);
      if (gap_chk && rx_bits != 0)             check_val("bit_period", cyc - last_rise, 40);
      last_rise = cyc;
      rx_sh = {rx_sh[6:0], miso};
      rx_bits++;
      if (rx_bits == 8) begin
        rx_bits = 0;
        rx_n++;
        if (exp_q.size() == 0) check_val("rx_extra_byte", exp_q.size(), 1);
        else check_val("rx_byte", rx_sh, exp_q.pop_front());
      end
    end
    sclk_d = spi_clk;
  end

  // receiver on the small instance, also checks miso does not move on a rising spi_clk
  logic [7:0] rxs_sh = 8'h00;
  int         rxs_bits = 0;
  logic       sclks_d = 1'b0;
  logic       misos_d = 1'b0;
  always @(negedge clk) begin
    if (!busy_s) rxs_bits = 0;
    else if (spi_clk_s && !sclks_d) begin
      check_val("s_miso_stable", miso_s, misos_d);
      rxs_sh = {rxs_sh[6:0], miso_s};
      rxs_bits++;
      if (rxs_bits == 8) begin
        rxs_bits = 0;
        if (exp_q_s.size() == 0) check_val("s_rx_extra_byte", exp_q_s.size(), 1);
        else check_val("s_rx_byte", rxs_sh, exp_q_s.pop_front());
      end
    end
    sclks_d = spi_clk_s;
    misos_d = miso_s;
  end

  // push the first nbytes of a default-parameter payload in the given mode
  task automatic push_payload(input int mode, input int nbytes);
    logic [47:0] pat;
    logic [7:0]  l;
    logic [7:0]  b;
    int          p;
    pat = 48'hBBA0D2BBA0D2;
    l   = 8'h01;
    for (int i = 0; i < nbytes; i++) begin
      if (i < 9) b = 8'h00;
      else if (i == 9) b = 8'hFF;
      else if (i < 100) begin
        p = i - 10;
        b = pat[8*(5 - p % 6) +: 8];
        if (mode == 2) b = p[7:0];
        if (mode == 3) b = ~b;
`ifdef SPI_PAYLOAD_GEN_LFSR_EN
        if (mode == 1) b = l;
`endif
        l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end else b = 8'h00;
      exp_q.push_back(b);
    end
  endtask

  // called at a negedge; t0 is the cycle number of the edge that samples start
  task automatic kick(output int t0);
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int t0, input int lat);
    int n = 0;
    while (!done && n < lat + 200) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, cyc - t0, lat);
  endtask

  task automatic wait_bc(input logic [15:0] tgt, input int lim);
    int n = 0;
    while (byte_count != tgt && n < lim) begin
      @(negedge clk);
      n++;
    end
    check_val("wait_byte_count", byte_count, tgt);
  endtask

  task automatic wait_rise(input int t0);
    int n = 0;
    while (!spi_clk && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("first_rise", cyc - t0, 21);
  endtask

  initial begin
    int t0, d0, n;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; pattern_mode = 2'd0; byte_gap = 16'd0;
    start_s = 1'b0; abort_s = 1'b0; pattern_mode_s = 2'd3; byte_gap_s = 16'd0;
    repeat (3) @(negedge clk);
    check_val("rst_spi_clk", spi_clk, 0);
    check_val("rst_miso", miso, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_byte_count", byte_count, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // run A: mode 0, no gap, extra start pulses with different settings while busy
    push_payload(0, 102);
    check_val("busy_before_start", busy, 0);
    kick(t0);
    check_val("busy_rise", busy, 1);
    wait_rise(t0);
    for (int k = 0; k < 2; k++) begin
      repeat (7000) @(negedge clk);
      start = 1'b1; pattern_mode = 2'd2; byte_gap = 16'd7;
      @(negedge clk);
      start = 1'b0; pattern_mode = 2'd0; byte_gap = 16'd0;
    end
    wait_done("A_done_latency", t0, 102*320 + 2);
    check_val("A_busy_with_done", busy, 0);
    check_val("A_byte_count", byte_count, 102);
    check_val("A_queue_left", exp_q.size(), 0);
    @(negedge clk);
    check_val("A_done_width", done, 0);

    // run B: mode 2 with a 50-cycle gap, aborted during frame 7
    pattern_mode = 2'd2; byte_gap = 16'd50;
    push_payload(2, 47);
    gap_chk = 1'b1;
    kick(t0);
    wait_rise(t0);
    wait_bc(16'd47, 20000);
    repeat (100) @(negedge clk);
    d0 = done_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort_busy", busy, 0);
    check_val("abort_spi_clk", spi_clk, 0);
    check_val("abort_miso", miso, 0);
    check_val("abort_byte_count", byte_count, 47);
    gap_chk = 1'b0;
    repeat (500) @(negedge clk);
    check_val("abort_no_done", done_cnt, d0);
    check_val("abort_count_held", byte_count, 47);
    check_val("B_queue_left", exp_q.size(), 0);

    // run C: mode 1 full payload after the abort
    pattern_mode = 2'd1; byte_gap = 16'd0;
    push_payload(1, 102);
    kick(t0);
    wait_done("C_done_latency", t0, 102*320 + 2);
    check_val("C_byte_count", byte_count, 102);
    check_val("C_queue_left", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    // run D: reset in the middle of the header byte
    pattern_mode = 2'd0;
    push_payload(0, 9);
    kick(t0);
    wait_bc(16'd9, 4000);
    repeat (50) @(negedge clk);
    check_val("D_busy_before_reset", busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check_val("D_rst_spi_clk", spi_clk, 0);
    check_val("D_rst_miso", miso, 0);
    check_val("D_rst_busy", busy, 0);
    check_val("D_rst_done", done, 0);
    check_val("D_rst_byte_count", byte_count, 0);
    reset_n = 1'b1;
    check_val("D_queue_left", exp_q.size(), 0);
    @(negedge clk);

    // small instance: header FF then inverted 5A
    exp_q_s.push_back(8'hFF);
    exp_q_s.push_back(8'hA5);
    start_s = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start_s = 1'b0;
    n = 0;
    while (!done_s && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("S_done_latency", cyc - t0, 34);
    check_val("S_byte_count", byte_count_s, 2);
    check_val("S_busy_with_done", busy_s, 0);
    check_val("S_queue_left", exp_q_s.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
